// File: rtl/fetch_unit.sv
// Instruction fetch with IF/ID register. Build with FETCH_PERF_EN to include the perf counters.
// Fetch-to-IF/ID latency is L+1 edges from request; ready low holds the request; FIFO full stops issue.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall_if,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            redirect_ex,
  input  logic [XLEN-1:0] redirect_ex_target,
  input  logic            jump_id,
  input  logic [XLEN-1:0] jump_id_target,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_redirect_cnt
);

  localparam int          AW      = $clog2(BUF_DEPTH);
  localparam int          CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [XLEN-1:0] pc;
  logic            req_pending;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   fifo_rd;
  logic [AW-1:0]   fifo_wr;
  logic [AW-1:0]   pq_rd;
  logic [AW-1:0]   pq_wr;
  logic [31:0]     fifo_instr [BUF_DEPTH];
  logic [XLEN-1:0] fifo_pc    [BUF_DEPTH];
  logic [XLEN-1:0] pq         [BUF_DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW:0]     outstanding;
  logic            req_fire;
  logic            rsp_keep;
  logic            id_load;
  logic            pop;
  logic            bypass;
  logic            push;

  assign redirect    = redirect_ex | (jump_id & ~stall_if);
  assign target      = (redirect_ex ? redirect_ex_target : jump_id_target) & ~XLEN'(3);
  assign outstanding = {1'b0, inflight} + {1'b0, fifo_cnt};

  // A request already on the bus is held even if stall_if rises, so the address never changes under it.
  assign imem_req_valid = rst_n & ~redirect &
                          (req_pending | (~stall_if & (outstanding < DEPTH_W)));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep = imem_rsp_valid & ~redirect & (drop_cnt == '0);
  assign id_load  = ~redirect & ~flush_id & ~stall_id;
  assign pop      = id_load & (fifo_cnt != '0);
  assign bypass   = id_load & (fifo_cnt == '0) & rsp_keep;
  assign push     = rsp_keep & ~bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pending <= 1'b0;
      inflight    <= '0;
      drop_cnt    <= '0;
      fifo_cnt    <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Everything still in flight is stale; a response arriving now is dropped on the spot.
        pc          <= target;
        req_pending <= 1'b0;
        drop_cnt    <= inflight - CW'(imem_rsp_valid);
        fifo_cnt    <= '0;
        fifo_rd     <= '0;
        fifo_wr     <= '0;
        pq_rd       <= '0;
        pq_wr       <= '0;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        req_pending <= imem_req_valid & ~imem_req_ready;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        if (push)     fifo_wr <= fifo_wr + AW'(1);
        if (pop)      fifo_rd <= fifo_rd + AW'(1);
        if (req_fire) pq_wr   <= pq_wr + AW'(1);
        if (rsp_keep) pq_rd   <= pq_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]    <= pq[pq_rd];
    end
    if (req_fire) pq[pq_wr] <= pc;
  end

  // A flush leaves the FIFO alone so the instruction behind the squashed one is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP;
    end else if (redirect_ex || flush_id) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
    end else if (!stall_id) begin
      if (pop) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= fifo_pc[fifo_rd];
        if_id_instr <= fifo_instr[fifo_rd];
      end else if (bypass) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pq[pq_rd];
        if_id_instr <= imem_rsp_data;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!if_id_valid && !stall_id) bubble_cnt <= bubble_cnt + 32'd1;
      if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign perf_bubble_cnt   = bubble_cnt;
  assign perf_redirect_cnt = redirect_cnt;
`else
  assign perf_bubble_cnt   = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        redirect_ex;
  logic [31:0] redirect_ex_target;
  logic        jump_id;
  logic [31:0] jump_id_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_redirect_cnt;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int ecnt = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .redirect_ex(redirect_ex), .redirect_ex_target(redirect_ex_target),
    .jump_id(jump_id), .jump_id_target(jump_id_target),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .perf_bubble_cnt(perf_bubble_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory: a request accepted at edge n is presented during the cycle that ends at edge n+lat.
  typedef struct {int due; logic [31:0] addr;} mreq_t;
  mreq_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      ecnt++;
      if (imem_req_valid && imem_req_ready) mq.push_back(mreq_t'{ecnt + lat, imem_req_addr});
      if (mq.size() > 0 && mq[0].due == ecnt + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= instr_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0;
    redirect_ex = 1'b0; redirect_ex_target = '0;
    jump_id = 1'b0; jump_id_target = '0;
    lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_if_id_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_if_id_pc got=%h exp=0", if_id_pc); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_if_id_instr got=%h exp=%h", if_id_instr, NOP); end
    checks++; if (perf_bubble_cnt !== 32'h0) begin errors++; $display("FAIL reset_bubble got=%0d exp=0", perf_bubble_cnt); end
    checks++; if (perf_redirect_cnt !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%0d exp=0", perf_redirect_cnt); end
  endtask

  task automatic test_stream();
    do_reset(1);
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_c0 got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    tick();
    checks++; if (imem_req_addr !== 32'h4 || if_id_valid !== 1'b0) begin errors++; $display("FAIL stream_c1 got=%h/%b exp=4/0", imem_req_addr, if_id_valid); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'((k-2)*4)) begin errors++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", k, if_id_valid, if_id_pc, (k-2)*4); end
      checks++; if (if_id_instr !== instr_of(32'((k-2)*4))) begin errors++; $display("FAIL stream_instr%0d got=%h exp=%h", k, if_id_instr, instr_of(32'((k-2)*4))); end
      checks++; if (imem_req_addr !== 32'(k*4)) begin errors++; $display("FAIL stream_addr%0d got=%h exp=%h", k, imem_req_addr, k*4); end
    end
    stall_if = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_if_req got=%b exp=0", imem_req_valid); end
    tick(); stall_if = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin errors++; $display("FAIL stall_if_resume got=%b/%h exp=1/14", imem_req_valid, imem_req_addr); end
    checks++; if (if_id_pc !== 32'h10) begin errors++; $display("FAIL stall_if_id got=%h exp=10", if_id_pc); end
    tick();
    checks++; if (if_id_valid !== 1'b0 || imem_req_addr !== 32'h18) begin errors++; $display("FAIL stream_bubble got=%b/%h exp=0/18", if_id_valid, imem_req_addr); end
    tick();
    checks++; if (if_id_pc !== 32'h14) begin errors++; $display("FAIL stream_pc14 got=%h exp=14", if_id_pc); end
    stall_id = 1'b1; flush_id = 1'b1;
    tick(); stall_id = 1'b0; flush_id = 1'b0; #1;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", if_id_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_count got=%b exp=0", imem_req_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h18 || imem_req_addr !== 32'h20) begin errors++; $display("FAIL flush_pop got=%b/%h/%h exp=1/18/20", if_id_valid, if_id_pc, imem_req_addr); end
    tick();
    checks++; if (if_id_pc !== 32'h1C || imem_req_addr !== 32'h24) begin errors++; $display("FAIL flush_pop2 got=%h/%h exp=1c/24", if_id_pc, imem_req_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20) begin errors++; $display("FAIL flush_after got=%b/%h exp=1/20", if_id_valid, if_id_pc); end
  endtask

  task automatic test_redirect();
    int cnt;
    do_reset(3);
    tick(); tick();
    redirect_ex = 1'b1; redirect_ex_target = 32'h102; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req got=%b exp=0", imem_req_valid); end
    tick(); redirect_ex = 1'b0; redirect_ex_target = '0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%b/%h exp=1/100", imem_req_valid, imem_req_addr); end
    cnt = 1;
    while (!if_id_valid && cnt < 20) begin tick(); cnt++; end
    checks++; if (cnt !== 5) begin errors++; $display("FAIL redir_latency got=%0d exp=5 edges", cnt); end
    checks++; if (if_id_pc !== 32'h100 || if_id_instr !== instr_of(32'h100)) begin errors++; $display("FAIL redir_first got=%h/%h exp=100/%h", if_id_pc, if_id_instr, instr_of(32'h100)); end
    checks++; if (perf_redirect_cnt !== 32'(PERF)) begin errors++; $display("FAIL redir_perf got=%0d exp=%0d", perf_redirect_cnt, PERF); end
  endtask

  task automatic test_jump_priority();
    do_reset(1);
    tick();
    jump_id = 1'b1; jump_id_target = 32'h40; redirect_ex = 1'b1; redirect_ex_target = 32'h80; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL prio_req got=%b exp=0", imem_req_valid); end
    tick(); jump_id = 1'b0; redirect_ex = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin errors++; $display("FAIL prio_addr got=%b/%h exp=1/80", imem_req_valid, imem_req_addr); end
    tick();
    checks++; if (imem_req_addr !== 32'h84) begin errors++; $display("FAIL prio_addr2 got=%h exp=84", imem_req_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h80) begin errors++; $display("FAIL prio_if_id got=%b/%h exp=1/80", if_id_valid, if_id_pc); end
    tick();
    checks++; if (if_id_pc !== 32'h84) begin errors++; $display("FAIL prio_if_id2 got=%h exp=84", if_id_pc); end
    stall_if = 1'b1; jump_id = 1'b1; jump_id_target = 32'h40; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL jump_stalled_req got=%b exp=0", imem_req_valid); end
    tick(); stall_if = 1'b0; jump_id = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'h8C || if_id_pc !== 32'h88) begin errors++; $display("FAIL jump_ignored got=%h/%h exp=8c/88", imem_req_addr, if_id_pc); end
    checks++; if (perf_redirect_cnt !== 32'(PERF)) begin errors++; $display("FAIL prio_perf got=%0d exp=%0d", perf_redirect_cnt, PERF); end
  endtask

  task automatic test_stall();
    do_reset(2);
    tick(); tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL l2_full got=%b exp=0", imem_req_valid); end
    tick(); tick();
    checks++; if (if_id_pc !== 32'h4 || imem_req_addr !== 32'hC) begin errors++; $display("FAIL l2_steady got=%h/%h exp=4/c", if_id_pc, imem_req_addr); end
    tick();
    stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got=%b/%b exp=0/0", i, imem_req_valid, if_id_valid); end
      tick();
    end
    stall_if = 1'b0; stall_id = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_full got=%b exp=0", imem_req_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== instr_of(32'h8)) begin errors++; $display("FAIL stall_drain8 got=%b/%h exp=1/8", if_id_valid, if_id_pc); end
    checks++; if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL stall_addr got=%h exp=10", imem_req_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin errors++; $display("FAIL stall_drain12 got=%b/%h exp=1/c", if_id_valid, if_id_pc); end
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_gap got=%b exp=0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10) begin errors++; $display("FAIL stall_next got=%b/%h exp=1/10", if_id_valid, if_id_pc); end
  endtask

  task automatic test_ready_low();
    do_reset(1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall_if = (i == 2); #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL ready_hold%0d got=%b/%h exp=1/0", i, imem_req_valid, imem_req_addr); end
      checks++; if (perf_bubble_cnt !== 32'(PERF*i)) begin errors++; $display("FAIL bubble%0d got=%0d exp=%0d", i, perf_bubble_cnt, PERF*i); end
      tick();
    end
    imem_req_ready = 1'b1; stall_if = 1'b0; #1;
    checks++; if (perf_bubble_cnt !== 32'(PERF*4)) begin errors++; $display("FAIL bubble4 got=%0d exp=%0d", perf_bubble_cnt, PERF*4); end
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin errors++; $display("FAIL ready_first got=%b/%h exp=1/0", if_id_valid, if_id_pc); end
    checks++; if (perf_bubble_cnt !== 32'(PERF*6)) begin errors++; $display("FAIL bubble6 got=%0d exp=%0d", perf_bubble_cnt, PERF*6); end
    tick();
    checks++; if (perf_bubble_cnt !== 32'(PERF*6)) begin errors++; $display("FAIL bubble_hold got=%0d exp=%0d", perf_bubble_cnt, PERF*6); end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    repeat (4) tick();
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b/%b exp=0/0", imem_req_valid, if_id_valid); end
    checks++; if (if_id_pc !== 32'h0 || if_id_instr !== NOP) begin errors++; $display("FAIL arst_if_id got=%h/%h exp=0/%h", if_id_pc, if_id_instr, NOP); end
    checks++; if (perf_bubble_cnt !== 32'h0) begin errors++; $display("FAIL arst_bubble got=%0d exp=0", perf_bubble_cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL arst_restart got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin errors++; $display("FAIL arst_first got=%b/%h exp=1/0", if_id_valid, if_id_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_jump_priority();
    test_stall();
    test_ready_low();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the hazard unit and decode. Holds the PC and issues in-order requests to instruction memory over a valid/ready channel. Buffers returned instructions in a small FIFO and presents one instruction per cycle to ID. Obeys stall_if/stall_id/flush_id from the hazard unit and the EX-stage and ID-stage redirects.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, instruction FIFO entries; also the maximum number of requests in flight plus buffered (power of 2, ≥2)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (always the current PC)
- imem_rsp_valid  in  1  response strobe, in request order, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- stall_if  in  1  freeze PC, issue no request
- stall_id  in  1  hold the IF/ID register
- flush_id  in  1  invalidate the IF/ID register
- redirect_ex  in  1  taken branch/jump resolved in EX (PCSrc)
- redirect_ex_target  in  XLEN  target for redirect_ex
- jump_id  in  1  early jump detected in ID
- jump_id_target  in  XLEN  target for jump_id
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_pc  out  XLEN  PC of the IF/ID instruction
- if_id_instr  out  32  instruction (NOP 32'h0000_0013 when invalid)
- perf_bubble_cnt  out  32  cycles with if_id_valid=0 and stall_id=0
- perf_redirect_cnt  out  32  accepted redirects

## Operation
- Outstanding count = in-flight requests + FIFO occupancy. A request is issued when !stall_if, no redirect this cycle, and count < BUF_DEPTH. The request is accepted on valid&ready, and PC ← PC+4 at that edge.
- imem_req_valid, once raised, stays high with a stable address until accepted unless a redirect occurs.
- Response handling: if drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise it is pushed into the FIFO with its PC, which is taken from a parallel PC queue.
- IF/ID load: at each edge with !stall_id, IF/ID takes the FIFO head if one exists (pop); otherwise it becomes invalid.
- Bypass: an empty FIFO plus a live response loads IF/ID directly, with no FIFO write.
- Redirect, with priority redirect_ex > jump_id:
  - PC ← target.
  - FIFO is cleared.
  - drop_cnt ← in-flight requests that are not yet responded, excluding a response dropped this cycle.
  - imem_req_valid=0 in that cycle.
- jump_id is ignored while stall_if=1.
- redirect_ex also invalidates IF/ID.
- flush_id invalidates IF/ID regardless of stall_id.
- Target addresses have bits [1:0] forced to 0.

## Timing
- Reset values: PC=RESET_PC, imem_req_valid=0, if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013, FIFO empty, drop_cnt=0, perf counters 0.
- First request is issued in the first cycle after rst_n deasserts.
- Fetch latency with memory latency L and no stalls: request accepted at cycle t, response at t+L, if_id_valid=1 after edge t+L.
- Redirect penalty: redirect at cycle r → target request issued at r+1 → IF/ID valid after edge r+1+L.
- Throughput is 1 instr/cycle when L < BUF_DEPTH.
- FIFO full (count = BUF_DEPTH): no request issued. An IF/ID pop in the same cycle does not free a slot until the next cycle.
- Response arriving while the FIFO is full cannot occur, by the count rule.
- Response arriving in a redirect cycle is dropped; it is not included in drop_cnt.
- stall_id=1 with a response: response goes to the FIFO; IF/ID is held.
- stall_id=1 and flush_id=1: IF/ID is invalidated; the FIFO is untouched.
- Reset mid-operation: asynchronous clear of all state; in-flight responses after reset are not expected. Memory is reset together with this block.

## Configuration
- FETCH_PERF_EN defined: perf_bubble_cnt and perf_redirect_cnt count as described, wrapping at 2^32.
- FETCH_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset release, L=1, ready=1 → addresses 0x0,0x4,0x8… on consecutive cycles; if_id_pc 0x0 valid two edges after reset release, then +4 each cycle.
- redirect_ex=1 with target 0x100 while 2 requests are in flight → both stale responses dropped; next valid if_id_pc=0x100; perf_redirect_cnt=1.
- jump_id (target 0x40) and redirect_ex (target 0x80) in the same cycle → PC=0x80, and 0x40 is never requested.
- stall_if and stall_id held 3 cycles with L=2 → no new requests; IF/ID unchanged; FIFO fills to 2; after release the instructions emerge in order with no loss or duplication.
- imem_req_ready=0 for 4 cycles → imem_req_valid stays high and imem_req_addr stays stable; perf_bubble_cnt increments on each cycle with IF/ID empty and no stall.
- rst_n asserted mid-stream → outputs return to reset values immediately (asynchronously); fetch restarts at RESET_PC.
